// File: rtl/spi_channel_rx_pkg.sv
// Shared types and defaults for the SPI multi-channel receiver.
package spi_channel_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

  localparam int unsigned DefNch    = 2;
  localparam int unsigned DefWordW  = 16;
  localparam int unsigned DefDataW  = 12;
  localparam int unsigned SyncDepth = 2;

endpackage

// File: rtl/spi_channel_rx_sync_edge.sv
// Multi-flop synchroniser with optional rise/fall pulse outputs on the synchronised level.
module spi_channel_rx_sync_edge
  import spi_channel_rx_pkg::*;
#(
  parameter bit EdgeEn = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncDepth-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SyncDepth-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SyncDepth-1];

  if (EdgeEn) begin : gen_edge
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= q_o;
      end
    end

    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;
  end else begin : gen_no_edge
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
  end

endmodule

// File: rtl/spi_channel_rx.sv
// SPI slave receiving NCH words per load-framed transfer into latched channel data.
// Optional macro SPI_FRAME_CHECK_EN: reject frames whose bit count is not exact.
module spi_channel_rx
  import spi_channel_rx_pkg::*;
#(
  parameter int unsigned NCH    = DefNch,
  parameter int unsigned WORD_W = DefWordW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  sdi,
  input  logic                  load,
  output logic                  sdo,
  output logic [NCH*DATA_W-1:0] ch_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [7:0]            frame_cnt
);

  localparam int unsigned FrameBits = NCH * WORD_W;
  localparam int unsigned CntW      = $clog2(FrameBits + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(FrameBits);
  localparam logic [CntW-1:0] CntSat  = CntW'(FrameBits + 1);

  logic sck_rise, sck_fall, load_rise, load_fall, sdi_s;
  logic unused_sck_lvl, unused_load_lvl, unused_sdi_rise, unused_sdi_fall;

  spi_channel_rx_sync_edge #(.EdgeEn(1'b1)) u_sync_sck (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (sck),
    .q_o    (unused_sck_lvl),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_channel_rx_sync_edge #(.EdgeEn(1'b1)) u_sync_load (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (load),
    .q_o    (unused_load_lvl),
    .rise_o (load_rise),
    .fall_o (load_fall)
  );

  spi_channel_rx_sync_edge #(.EdgeEn(1'b0)) u_sync_sdi (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (sdi),
    .q_o    (sdi_s),
    .rise_o (unused_sdi_rise),
    .fall_o (unused_sdi_fall)
  );

  state_e                state_q, state_d;
  logic                  start_pend_q, start_pend_d;
  logic [FrameBits-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NCH*DATA_W-1:0] ch_data_q, ch_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  sdo_q, sdo_d;
  logic                  start, commit_ok;

  // A load rise seen during COMMIT is held so the next frame starts from IDLE.
  assign start        = load_rise | start_pend_q;
  assign start_pend_d = (state_q == StCommit) & load_rise;

`ifdef SPI_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;
  assign commit_ok   = (cnt_q == CntFull);
  assign frame_err_d = (state_q == StCommit) & ~commit_ok;
  assign frame_err   = frame_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end
`else
  // Overlong frames keep their last FrameBits bits; short ones are dropped.
  assign commit_ok = (cnt_q >= CntFull);
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StShift;
      StShift:  if (load_fall) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    sdo_d         = sdo_q;
    unique case (state_q)
      StIdle: begin
        sdo_d = 1'b0;
        if (start) begin
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (sck_rise) begin
          shreg_d = FrameBits'({shreg_q, sdi_s});
          if (cnt_q != CntSat) cnt_d = cnt_q + CntW'(1);
        end
        if (sck_fall) sdo_d = shreg_q[FrameBits-1];
      end
      StCommit: begin
        if (commit_ok) begin
          // Channel 0 arrived first, so it sits in the most significant word.
          for (int k = 0; k < NCH; k++) begin
            ch_data_d[k*DATA_W +: DATA_W] = shreg_q[(NCH-1-k)*WORD_W +: DATA_W];
          end
          frame_valid_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_pend_q  <= 1'b0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
      sdo_q         <= 1'b0;
    end else begin
      start_pend_q  <= start_pend_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      sdo_q         <= sdo_d;
    end
  end

  assign sdo         = sdo_q;
  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_spi_channel_rx.sv
// Scoreboard bench for spi_channel_rx: default (2 ch) and 4-channel instances.
module tb_spi_channel_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic load2 = 1'b0;
  logic load4 = 1'b0;

  logic        sdo2, fv2, fe2;
  logic [23:0] ch2;
  logic [7:0]  cnt2;
  logic        sdo4, fv4, fe4;
  logic [47:0] ch4;
  logic [7:0]  cnt4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [47:0] data;
    logic [7:0]  cnt;
    logic        err;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];
  exp_t e2, e4;
  logic [23:0] m_data2 = '0;
  logic [7:0]  m_cnt2  = '0;
  logic [47:0] m_data4 = '0;
  logic [7:0]  m_cnt4  = '0;

  spi_channel_rx dut2 (
    .clk         (clk),
    .reset       (rst_n),
    .sck         (sck),
    .sdi         (sdi),
    .load        (load2),
    .sdo         (sdo2),
    .ch_data     (ch2),
    .frame_valid (fv2),
    .frame_err   (fe2),
    .frame_cnt   (cnt2)
  );

  spi_channel_rx #(.NCH(4), .WORD_W(16), .DATA_W(12)) dut4 (
    .clk         (clk),
    .reset       (rst_n),
    .sck         (sck),
    .sdi         (sdi),
    .load        (load4),
    .sdo         (sdo4),
    .ch_data     (ch4),
    .frame_valid (fv4),
    .frame_err   (fe4),
    .frame_cnt   (cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: every output pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && (fv2 || fe2)) begin
      if (q2.size() == 0) begin
        check("unexpected_out2", {62'd0, fv2, fe2}, 64'd0);
      end else begin
        e2 = q2.pop_front();
        check("kind2", {62'd0, fv2, fe2}, e2.err ? 64'd1 : 64'd2);
        check("data2", {40'd0, ch2}, {40'd0, e2.data[23:0]});
        check("cnt2", {56'd0, cnt2}, {56'd0, e2.cnt});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (fv4 || fe4)) begin
      if (q4.size() == 0) begin
        check("unexpected_out4", {62'd0, fv4, fe4}, 64'd0);
      end else begin
        e4 = q4.pop_front();
        check("kind4", {62'd0, fv4, fe4}, e4.err ? 64'd1 : 64'd2);
        check("data4", {16'd0, ch4}, {16'd0, e4.data});
        check("cnt4", {56'd0, cnt4}, {56'd0, e4.cnt});
      end
    end
  end

  task automatic push2(input logic [23:0] data, input logic err);
    if (!err) begin
      m_data2 = data;
      m_cnt2  = m_cnt2 + 8'd1;
    end
    q2.push_back('{data: {24'd0, m_data2}, cnt: m_cnt2, err: err});
  endtask

  task automatic push4(input logic [47:0] data);
    m_data4 = data;
    m_cnt4  = m_cnt4 + 8'd1;
    q4.push_back('{data: m_data4, cnt: m_cnt4, err: 1'b0});
  endtask

  // MSB first; sdi changes with the sck falling edge, sampled on the rise.
  task automatic send_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = bits[i];
      #20 sck = 1'b1;
      #20 sck = 1'b0;
    end
  endtask

  task automatic frame(input bit four, input logic [63:0] bits, input int n);
    @(negedge clk);
    #2;
    if (four) load4 = 1'b1;
    else load2 = 1'b1;
    #40;
    send_bits(bits, n);
    #40;
    load2 = 1'b0;
    load4 = 1'b0;
    #200;
  endtask

  initial begin
    logic [15:0] d0, d1;
    #33;
    check("rst_ch2", {40'd0, ch2}, 64'd0);
    check("rst_cnt2", {56'd0, cnt2}, 64'd0);
    check("rst_fv2", {63'd0, fv2}, 64'd0);
    check("rst_fe2", {63'd0, fe2}, 64'd0);
    check("rst_sdo2", {63'd0, sdo2}, 64'd0);
    check("rst_ch4", {16'd0, ch4}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #50;

    push2(24'h123ABC, 1'b0);
    frame(1'b0, 64'h0ABC_0123, 32);

    // Loopback: after a full frame the register MSB is the first bit sent.
    push2({12'hAAA, 12'h555}, 1'b0);
    @(negedge clk);
    #2 load2 = 1'b1;
    #40;
    send_bits(64'hF555_0AAA, 32);
    #100;
    check("sdo_loopback", {63'd0, sdo2}, 64'd1);
    load2 = 1'b0;
    #200;
    check("sdo_idle", {63'd0, sdo2}, 64'd0);

    push2({12'h678, 12'h234}, 1'b0);
    frame(1'b0, 64'h1234_5678, 32);

`ifdef SPI_FRAME_CHECK_EN
    push2(24'h0, 1'b1);
`endif
    frame(1'b0, 64'h2AAA_AAAA, 31);
    check("short_data", {40'd0, ch2}, {40'd0, m_data2});
    check("short_cnt", {56'd0, cnt2}, {56'd0, m_cnt2});

`ifdef SPI_FRAME_CHECK_EN
    push2(24'h0, 1'b1);
`else
    push2({12'h456, 12'hDEF}, 1'b0);
`endif
    frame(1'b0, 64'h1_0DEF_0456, 33);
    check("long_data", {40'd0, ch2}, {40'd0, m_data2});

    // Counter wrap from a clean reset.
    rst_n = 1'b0;
    #30 rst_n = 1'b1;
    m_data2 = '0;
    m_cnt2  = '0;
    #50;
    for (int i = 0; i < 256; i++) begin
      d0 = 16'(i * 3 + 1);
      d1 = ~16'(i);
      push2({d1[11:0], d0[11:0]}, 1'b0);
      frame(1'b0, {32'd0, d0, d1}, 32);
    end
    check("wrap_cnt", {56'd0, cnt2}, 64'd0);

    // Reset in the middle of a frame discards it.
    @(negedge clk);
    #2 load2 = 1'b1;
    #40;
    send_bits(64'h3FF, 10);
    load2 = 1'b0;
    rst_n = 1'b0;
    #30;
    check("midrst_ch2", {40'd0, ch2}, 64'd0);
    check("midrst_cnt2", {56'd0, cnt2}, 64'd0);
    rst_n = 1'b1;
    m_data2 = '0;
    m_cnt2  = '0;
    #50;
    push2(24'hFFFFFF, 1'b0);
    frame(1'b0, 64'hFFFF_FFFF, 32);
    check("after_rst_cnt", {56'd0, cnt2}, 64'd1);

    push4(48'h444333222111);
    frame(1'b1, 64'h1111_2222_3333_4444, 64);
    check("nch4_data", {16'd0, ch4}, 64'h0000_4443_3322_2111);

    #200;
    check("q2_drained", 64'(q2.size()), 64'd0);
    check("q4_drained", 64'(q4.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
